// File: rtl/mem_request_ctrl.sv
// Memory request sequencer between the control unit and the cache interface.
// Holds data requests until dhit, formats sub-word lanes, and latches halt/error.
module mem_request_ctrl #(
    parameter int WORD_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 255
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  ihit,
    input  logic                  dhit,
    input  logic                  dread,
    input  logic                  dwrite,
    input  logic                  halt,
    input  logic [1:0]            size,
    input  logic                  lsigned,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [WORD_W-1:0]     wdata,
    input  logic [WORD_W-1:0]     dmemload,
    output logic                  imemREN,
    output logic                  dmemREN,
    output logic                  dmemWEN,
    output logic [ADDR_W-1:0]     dmemaddr,
    output logic [WORD_W-1:0]     dmemstore,
    output logic [WORD_W/8-1:0]   dmembe,
    output logic [WORD_W-1:0]     ldata,
    output logic                  ld_valid,
    output logic                  pc_en,
    output logic                  halted,
    output logic                  err,
    output logic [1:0]            err_code
);
    localparam int BYTES = WORD_W / 8;
    localparam int OFS_W = $clog2(BYTES);
    localparam int CNT_W = $clog2(MAX_WAIT);

    typedef enum logic [2:0] {IDLE, DREQ, DONE, HALT, ERR} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [1:0]          errc_q, errc_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [WORD_W-1:0]   wdata_q;
    logic [1:0]          size_q;
    logic                signed_q;
    logic                wr_q;
    logic [WORD_W-1:0]   ldata_q;
    logic                latch_en, cap_en, misaligned;

    logic [OFS_W-1:0]    ofs;
    logic [OFS_W+2:0]    sh;
    logic [WORD_W-1:0]   st_byte, st_half, st_fmt, ld_shift, ld_fmt;
    logic [BYTES-1:0]    be_byte, be_half, be_fmt;

    assign misaligned = (size == 2'd3) ||
                        (size == 2'd0 && addr[OFS_W-1:0] != '0) ||
                        (size == 2'd2 && addr[0]);

    // Big-endian lanes: byte offset 0 lives in the most significant byte.
    assign ofs      = addr_q[OFS_W-1:0];
    assign sh       = {ofs, 3'b000};
    assign st_byte  = {wdata_q[7:0],  {(WORD_W-8){1'b0}}}  >> sh;
    assign st_half  = {wdata_q[15:0], {(WORD_W-16){1'b0}}} >> sh;
    assign be_byte  = {1'b1,  {(BYTES-1){1'b0}}} >> ofs;
    assign be_half  = {2'b11, {(BYTES-2){1'b0}}} >> ofs;
    assign ld_shift = dmemload << sh;

    always_comb begin
        st_fmt = wdata_q;
        be_fmt = '1;
        ld_fmt = dmemload;
        case (size_q)
            2'd1: begin
                st_fmt = st_byte;
                be_fmt = be_byte;
                ld_fmt = {{(WORD_W-8){signed_q & ld_shift[WORD_W-1]}}, ld_shift[WORD_W-1 -: 8]};
            end
            2'd2: begin
                st_fmt = st_half;
                be_fmt = be_half;
                ld_fmt = {{(WORD_W-16){signed_q & ld_shift[WORD_W-1]}}, ld_shift[WORD_W-1 -: 16]};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        errc_d    = errc_q;
        latch_en  = 1'b0;
        cap_en    = 1'b0;
        imemREN   = 1'b0;
        dmemREN   = 1'b0;
        dmemWEN   = 1'b0;
        dmemaddr  = '0;
        dmemstore = '0;
        dmembe    = '0;
        pc_en     = 1'b0;
        ld_valid  = 1'b0;
        case (state_q)
            IDLE: begin
                imemREN = 1'b1;
                pc_en   = ihit & ~dread & ~dwrite & ~halt;
                if (ihit) begin
                    if (halt) begin
                        state_d = HALT;
                    end else if (dread | dwrite) begin
                        if (misaligned) begin
                            state_d = ERR;
                            errc_d  = 2'd1;
                        end else begin
                            state_d  = DREQ;
                            latch_en = 1'b1;
                            cnt_d    = '0;
                        end
                    end
                end
            end
            DREQ: begin
                dmemREN   = ~wr_q;
                dmemWEN   = wr_q;
                dmemaddr  = {addr_q[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
                dmemstore = wr_q ? st_fmt : '0;
                dmembe    = be_fmt;
                // A hit on the last allowed cycle still completes the access.
                if (dhit) begin
                    state_d = DONE;
                    cap_en  = ~wr_q;
                end else if (cnt_q == CNT_W'(MAX_WAIT - 1)) begin
                    state_d = ERR;
                    errc_d  = 2'd2;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                pc_en    = 1'b1;
                ld_valid = ~wr_q;
                state_d  = IDLE;
                cnt_d    = '0;
            end
            HALT, ERR: ;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            errc_q   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            size_q   <= '0;
            signed_q <= 1'b0;
            wr_q     <= 1'b0;
            ldata_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            errc_q  <= errc_d;
            if (latch_en) begin
                addr_q   <= addr;
                wdata_q  <= wdata;
                size_q   <= size;
                signed_q <= lsigned;
                wr_q     <= dwrite;
            end
            if (cap_en) ldata_q <= ld_fmt;
        end
    end

    assign ldata    = ldata_q;
    assign halted   = (state_q == HALT);
    assign err      = (state_q == ERR);
    assign err_code = errc_q;

endmodule
